// File: rtl/ntt_pair_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ntt_pair_scheduler
// Purpose  : Walks every radix-2 NTT/INTT stage, issuing two butterfly
//            descriptors per accepted cycle, with a drain barrier per stage.
// Revision : 1.0 - initial release
// ============================================================================
module ntt_pair_scheduler #(
  parameter int N     = 256,
  parameter int LOG_N = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_intt,
  input  logic             pipe_idle,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG_N-1:0] out_idx_a0,
  output logic [LOG_N-1:0] out_idx_b0,
  output logic [LOG_N-1:0] out_idx_a1,
  output logic [LOG_N-1:0] out_idx_b1,
  output logic [LOG_N-1:0] out_tf0,
  output logic [LOG_N-1:0] out_tf1,
  output logic [7:0]       out_stage,
  output logic             out_is_intt,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  typedef struct packed {
    logic [LOG_N-1:0] a;
    logic [LOG_N-1:0] b;
    logic [LOG_N-1:0] tf;
  } bfly_t;

  localparam logic [LOG_N-1:0] C_ONE        = LOG_N'(1);
  localparam logic [LOG_N-1:0] C_TWO        = LOG_N'(2);
  localparam logic [LOG_N-1:0] C_ALL1       = '1;
  localparam logic [LOG_N-1:0] C_HALF       = LOG_N'(N / 2);
  localparam logic [LOG_N-1:0] C_LAST_P     = LOG_N'(N / 2 - 2);
  localparam logic [7:0]       C_LAST_STAGE = 8'(LOG_N - 1);

  // (N-1) >> e equals (N >> e) - 1 for power-of-two N, keeping the inverse
  // twiddle inside LOG_N bits.
  function automatic bfly_t f_bfly(input logic [7:0] stage, input logic [LOG_N-1:0] q,
                                   input logic intt);
    logic [7:0]       e;
    logic [LOG_N-1:0] len;
    logic [LOG_N-1:0] g;
    logic [LOG_N-1:0] j;
    bfly_t            r;
    e    = intt ? stage : (C_LAST_STAGE - stage);
    len  = C_ONE << e;
    g    = q >> e;
    j    = (g << (e + 8'd1)) | (q & (len - C_ONE));
    r.a  = j;
    r.b  = j + len;
    r.tf = intt ? ((C_ALL1 >> e) - g) : ((C_HALF >> e) + g);
    return r;
  endfunction

  state_e           state_q;
  logic [7:0]       stage_q, stage_d;
  logic [LOG_N-1:0] p_q, p_d;
  logic             mode_q, mode_d;
  logic             load_d;
  logic             valid_q, last_q, busy_q, done_q;
  logic [LOG_N-1:0] a0_q, b0_q, a1_q, b1_q, tf0_q, tf1_q;
  bfly_t            bf0_d, bf1_d;

  // Selects the (stage, pair, mode) of the descriptor loaded at the next edge.
  always_comb begin
    stage_d = stage_q;
    p_d     = p_q;
    mode_d  = mode_q;
    load_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        stage_d = '0;
        p_d     = '0;
        mode_d  = is_intt;
        load_d  = start;
      end
      S_ISSUE: begin
        p_d    = p_q + C_TWO;
        load_d = out_ready && !last_q;
      end
      S_DRAIN: begin
        stage_d = stage_q + 8'd1;
        p_d     = '0;
        load_d  = pipe_idle && (stage_q != C_LAST_STAGE);
      end
      default: ;
    endcase
  end

  assign bf0_d = f_bfly(stage_d, p_d, mode_d);
  assign bf1_d = f_bfly(stage_d, p_d + C_ONE, mode_d);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      p_q     <= '0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a0_q    <= '0;
      b0_q    <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      tf0_q   <= '0;
      tf1_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (load_d) begin
        stage_q <= stage_d;
        p_q     <= p_d;
        mode_q  <= mode_d;
        valid_q <= 1'b1;
        busy_q  <= 1'b1;
        last_q  <= (p_d == C_LAST_P);
        a0_q    <= bf0_d.a;
        b0_q    <= bf0_d.b;
        tf0_q   <= bf0_d.tf;
        a1_q    <= bf1_d.a;
        b1_q    <= bf1_d.b;
        tf1_q   <= bf1_d.tf;
      end
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (out_ready && last_q) begin
            state_q <= S_DRAIN;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (pipe_idle) begin
            if (stage_q == C_LAST_STAGE) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid   = valid_q;
  assign out_idx_a0  = a0_q;
  assign out_idx_b0  = b0_q;
  assign out_idx_a1  = a1_q;
  assign out_idx_b1  = b1_q;
  assign out_tf0     = tf0_q;
  assign out_tf1     = tf1_q;
  assign out_stage   = stage_q;
  assign out_is_intt = mode_q;
  assign out_last    = last_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ntt_pair_scheduler.sv
`default_nettype none
// Bench for ntt_pair_scheduler: N=8 golden tables, directed corner sequences,
// and randomized handshakes on N=8/N=32 against a loop-based reference model.
module tb_ntt_pair_scheduler;

  typedef struct {
    int intt;
    int a0, b0, a1, b1;
    int tf0, tf1;
    int stage;
    int last;
  } vec_t;

  logic clk;
  logic reset_n, start, is_intt, pipe_idle, out_ready;

  logic       v8, it8, l8, bz8, dn8;
  logic [2:0] a0_8, b0_8, a1_8, b1_8, t0_8, t1_8;
  logic [7:0] st8;
  logic       v32, it32, l32, bz32, dn32;
  logic [4:0] a0_32, b0_32, a1_32, b1_32, t0_32, t1_32;
  logic [7:0] st32;

  int   o_v, o_it, o_l, o_bz, o_dn, o_a0, o_b0, o_a1, o_b1, o_t0, o_t1, o_st;
  bit   sel32;
  int   cur_n, cur_logn;
  int   n_vec, n_mis;
  vec_t tbl[12];
  vec_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ntt_pair_scheduler #(.N(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start), .is_intt(is_intt),
    .pipe_idle(pipe_idle), .out_valid(v8), .out_ready(out_ready),
    .out_idx_a0(a0_8), .out_idx_b0(b0_8), .out_idx_a1(a1_8), .out_idx_b1(b1_8),
    .out_tf0(t0_8), .out_tf1(t1_8), .out_stage(st8), .out_is_intt(it8),
    .out_last(l8), .busy(bz8), .done(dn8)
  );

  ntt_pair_scheduler #(.N(32)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .start(start), .is_intt(is_intt),
    .pipe_idle(pipe_idle), .out_valid(v32), .out_ready(out_ready),
    .out_idx_a0(a0_32), .out_idx_b0(b0_32), .out_idx_a1(a1_32), .out_idx_b1(b1_32),
    .out_tf0(t0_32), .out_tf1(t1_32), .out_stage(st32), .out_is_intt(it32),
    .out_last(l32), .busy(bz32), .done(dn32)
  );

  always_comb begin
    if (sel32) begin
      o_v  = int'(v32);   o_it = int'(it32);  o_l  = int'(l32);
      o_bz = int'(bz32);  o_dn = int'(dn32);  o_st = int'(st32);
      o_a0 = int'(a0_32); o_b0 = int'(b0_32); o_a1 = int'(a1_32);
      o_b1 = int'(b1_32); o_t0 = int'(t0_32); o_t1 = int'(t1_32);
    end else begin
      o_v  = int'(v8);    o_it = int'(it8);   o_l  = int'(l8);
      o_bz = int'(bz8);   o_dn = int'(dn8);   o_st = int'(st8);
      o_a0 = int'(a0_8);  o_b0 = int'(b0_8);  o_a1 = int'(a1_8);
      o_b1 = int'(b1_8);  o_t0 = int'(t0_8);  o_t1 = int'(t1_8);
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_mis++;
    $display("FAIL %s: bound expired or unexpected event (t=%0t)", nm, $time);
  endtask

  task automatic load_table(input int intt);
    exp_q.delete();
    foreach (tbl[i]) if (tbl[i].intt == intt) exp_q.push_back(tbl[i]);
  endtask

  // Enumerates butterflies group by group, offset by offset, then pairs them.
  task automatic build_model(input int intt);
    int   len, ng;
    int   ba[$], bb[$], bt[$];
    vec_t d;
    exp_q.delete();
    for (int s = 0; s < cur_logn; s++) begin
      len = (intt != 0) ? (1 << s) : (cur_n >> (s + 1));
      ng  = cur_n / (2 * len);
      ba.delete(); bb.delete(); bt.delete();
      for (int g = 0; g < ng; g++) begin
        for (int k = 0; k < len; k++) begin
          ba.push_back(g * 2 * len + k);
          bb.push_back(g * 2 * len + k + len);
          bt.push_back((intt != 0) ? (cur_n / len - 1 - g) : (cur_n / (2 * len) + g));
        end
      end
      for (int i = 0; i < ba.size(); i += 2) begin
        d = '{intt, ba[i], bb[i], ba[i+1], bb[i+1], bt[i], bt[i+1], s,
              (i == ba.size() - 2) ? 1 : 0};
        exp_q.push_back(d);
      end
    end
  endtask

  // Called at a negedge with the DUT idle; checks every cycle until done.
  task automatic run_xform(input bit intt, input int rdy_pct, input int idl_pct,
                           input int stall_at, input int stall_len, input int hold_len,
                           input bit poke);
    int   cyc, hold, xfers, total, phase, lat;
    bit   fin;
    vec_t h;
    total = exp_q.size();
    phase = 0; cyc = 0; hold = 0; xfers = 0; fin = 1'b0;
    lat   = cur_logn * (cur_n / 4 + 1) + 1;
    start = 1'b1; is_intt = intt; out_ready = 1'b1; pipe_idle = 1'b1;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start   = 1'b0;
      is_intt = 1'($urandom);
      if (cyc > 4000) begin
        fail_now("timeout");
        fin = 1'b1;
      end else if (phase == 0) begin
        chk("issue_valid", o_v, 1);
        chk("issue_done", o_dn, 0);
        chk("issue_busy", o_bz, 1);
        chk("mode", o_it, int'(intt));
        pipe_idle = 1'($urandom);
        if (exp_q.size() == 0) begin
          fail_now("extra_descriptor");
          fin = 1'b1;
        end else begin
          h = exp_q[0];
          chk("a0", o_a0, h.a0);   chk("b0", o_b0, h.b0);
          chk("a1", o_a1, h.a1);   chk("b1", o_b1, h.b1);
          chk("tf0", o_t0, h.tf0); chk("tf1", o_t1, h.tf1);
          chk("stage", o_st, h.stage);
          chk("last", o_l, h.last);
          if (cyc >= stall_at && cyc < stall_at + stall_len) out_ready = 1'b0;
          else out_ready = ($urandom_range(0, 99) < rdy_pct);
          if (out_ready) begin
            xfers++;
            void'(exp_q.pop_front());
            if (h.last != 0) begin
              phase = 1;
              hold  = hold_len;
            end
          end
        end
      end else if (phase == 1) begin
        chk("drain_valid", o_v, 0);
        chk("drain_done", o_dn, 0);
        chk("drain_busy", o_bz, 1);
        out_ready = 1'($urandom);
        if (hold > 0) begin
          pipe_idle = 1'b0;
          hold--;
        end else begin
          pipe_idle = ($urandom_range(0, 99) < idl_pct);
        end
        if (pipe_idle) phase = (exp_q.size() == 0) ? 2 : 0;
      end else if (phase == 2) begin
        chk("done_pulse", o_dn, 1);
        chk("done_valid", o_v, 0);
        chk("done_busy", o_bz, 1);
        chk("transfers", xfers, total);
        if (rdy_pct == 100 && idl_pct == 100 && stall_len == 0 && hold_len == 0)
          chk("latency", cyc, lat);
        phase = 3;
      end else begin
        chk("post_done", o_dn, 0);
        chk("post_busy", o_bz, 0);
        chk("post_valid", o_v, 0);
        fin = 1'b1;
      end
      if (poke && phase < 3 && $urandom_range(0, 3) == 0) begin
        start   = 1'b1;
        is_intt = ~intt;
      end
    end
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, o_v, 0);  chk({tag, "_busy"}, o_bz, 0);
    chk({tag, "_done"}, o_dn, 0);  chk({tag, "_last"}, o_l, 0);
    chk({tag, "_mode"}, o_it, 0);  chk({tag, "_stage"}, o_st, 0);
    chk({tag, "_a0"}, o_a0, 0);    chk({tag, "_b0"}, o_b0, 0);
    chk({tag, "_a1"}, o_a1, 0);    chk({tag, "_b1"}, o_b1, 0);
    chk({tag, "_tf0"}, o_t0, 0);   chk({tag, "_tf1"}, o_t1, 0);
  endtask

  initial begin
    int  k;
    bit  m;
    n_vec = 0; n_mis = 0;
    tbl[0]  = '{0, 0, 4, 1, 5, 1, 1, 0, 0};
    tbl[1]  = '{0, 2, 6, 3, 7, 1, 1, 0, 1};
    tbl[2]  = '{0, 0, 2, 1, 3, 2, 2, 1, 0};
    tbl[3]  = '{0, 4, 6, 5, 7, 3, 3, 1, 1};
    tbl[4]  = '{0, 0, 1, 2, 3, 4, 5, 2, 0};
    tbl[5]  = '{0, 4, 5, 6, 7, 6, 7, 2, 1};
    tbl[6]  = '{1, 0, 1, 2, 3, 7, 6, 0, 0};
    tbl[7]  = '{1, 4, 5, 6, 7, 5, 4, 0, 1};
    tbl[8]  = '{1, 0, 2, 1, 3, 3, 3, 1, 0};
    tbl[9]  = '{1, 4, 6, 5, 7, 2, 2, 1, 1};
    tbl[10] = '{1, 0, 4, 1, 5, 1, 1, 2, 0};
    tbl[11] = '{1, 2, 6, 3, 7, 1, 1, 2, 1};

    reset_n = 1'b0; start = 1'b0; is_intt = 1'b0; pipe_idle = 1'b0; out_ready = 1'b0;
    sel32 = 1'b0; cur_n = 8; cur_logn = 3;
    repeat (3) @(negedge clk);
    chk_all_zero("reset8");
    sel32 = 1'b1; #1;
    chk_all_zero("reset32");
    sel32 = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Golden tables, full throughput
    load_table(0); run_xform(1'b0, 100, 100, 0, 0, 0, 1'b0);
    load_table(1); run_xform(1'b1, 100, 100, 0, 0, 0, 1'b0);
    // Backpressure: out_ready low for 3 cycles mid-stage
    load_table(0); run_xform(1'b0, 100, 100, 2, 3, 0, 1'b0);
    // Stage barrier: pipe_idle low for 5 cycles after every last descriptor
    load_table(0); run_xform(1'b0, 100, 100, 0, 0, 5, 1'b0);
    // Starts with toggled mode while busy must be ignored
    load_table(1); run_xform(1'b1, 100, 100, 0, 0, 0, 1'b1);

    // Reset during stage 1 aborts at once
    start = 1'b1; is_intt = 1'b0; out_ready = 1'b1; pipe_idle = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(o_v == 1 && o_st == 1) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) fail_now("reach_stage1");
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("after_reset_done", o_dn, 0);
    chk("after_reset_busy", o_bz, 0);
    load_table(0); run_xform(1'b0, 100, 100, 0, 0, 0, 1'b0);

    // Randomized handshakes, N=8
    for (int r = 0; r < 6; r++) begin
      m = 1'($urandom);
      build_model(int'(m));
      run_xform(m, $urandom_range(30, 100), $urandom_range(20, 100), 0, 0,
                $urandom_range(0, 3), 1'($urandom));
    end

    // Switch to the N=32 instance
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; sel32 = 1'b1; cur_n = 32; cur_logn = 5;
    @(negedge clk);
    build_model(0); run_xform(1'b0, 100, 100, 0, 0, 0, 1'b0);
    build_model(1); run_xform(1'b1, 100, 100, 0, 0, 0, 1'b0);
    for (int r = 0; r < 6; r++) begin
      m = 1'($urandom);
      build_model(int'(m));
      run_xform(m, $urandom_range(30, 100), $urandom_range(20, 100),
                $urandom_range(1, 20), $urandom_range(0, 4), $urandom_range(0, 3),
                1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ntt_pair_scheduler.md
# ntt_pair_scheduler

Sequencer that drives the write side of the NTT pipeline FIFO. On a start pulse it walks every stage of a radix-2 forward NTT (Cooley-Tukey) or inverse NTT (Gentleman-Sande) over an N-point polynomial. Each accepted cycle it issues two butterfly descriptors: four coefficient addresses and two twiddle-factor indices. Between stages it holds until the downstream butterfly/writeback path reports idle, so every stage reads fully committed results.

## Interface
- N, 256: transform size; power of two, N >= 4.
- LOG_N, $clog2(N): index width and stage count.
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- is_intt  in  1  mode; sampled with start. 0 = forward, 1 = inverse.
- pipe_idle  in  1  high when the FIFO is empty, no butterfly is in flight and all writebacks are committed.
- out_valid  out  1  descriptor valid; drives FIFO write_en.
- out_ready  in  1  FIFO can accept (enable && !full).
- out_idx_a0, out_idx_b0, out_idx_a1, out_idx_b1  out  LOG_N each  coefficient addresses for butterfly 0 (a0,b0) and butterfly 1 (a1,b1).
- out_tf0, out_tf1  out  LOG_N each  twiddle indices.
- out_stage  out  8  current stage number, 0..LOG_N-1.
- out_is_intt  out  1  latched mode.
- out_last  out  1  marks the final descriptor of the current stage.
- busy  out  1  high in every state other than IDLE.
- done  out  1  one-cycle pulse when the transform completes.

## Operation
- States:
  - IDLE -> ISSUE on start. Latch is_intt; clear stage s and pair counter p.
  - ISSUE -> DRAIN when the descriptor with out_last=1 is transferred.
  - DRAIN -> ISSUE when pipe_idle=1 and s < LOG_N-1; s increments and p clears.
  - DRAIN -> DONE when pipe_idle=1 and s = LOG_N-1.
  - DONE -> IDLE unconditionally after one cycle.
- Butterfly half-span len = 2^e:
  - forward: e = LOG_N-1-s, so len runs N/2 down to 1.
  - inverse: e = s, so len runs 1 up to N/2.
- Per-butterfly mapping for pair number q (0..N/2-1):
  - group g = q >> e
  - top index j = (g << (e+1)) | (q & (len-1))
  - idx_a = j, idx_b = j + len
  - forward tf = (N >> (e+1)) + g
  - inverse tf = (N >> e) - 1 - g
  - All arithmetic is modulo 2^LOG_N; no result overflows for legal N.
- Each descriptor carries butterfly 0 at q = p and butterfly 1 at q = p+1. p advances by 2 on each transfer.
- A stage has N/4 descriptors. out_last=1 when p = N/2-2.
- start is ignored while busy. is_intt is sampled only on an accepted start.

## Timing
- Reset (asynchronous assert, synchronous-safe release): state IDLE, all counters 0, and every output 0 (out_valid, busy, done, indices, tf, stage, out_last, out_is_intt).
- Latency:
  - First out_valid appears the cycle after start is sampled.
  - done rises exactly one cycle after the DRAIN->DONE transition condition is met.
- Handshake:
  - Transfer happens when out_valid && out_ready at a clock edge.
  - While out_valid=1 and out_ready=0, all payload outputs hold stable.
  - out_valid stays high through ISSUE with no bubbles; back-to-back transfers run at 1 descriptor/cycle.
- out_valid is 0 in IDLE, DRAIN and DONE. pipe_idle is ignored outside DRAIN.
- If pipe_idle is already high on entry to DRAIN, DRAIN lasts exactly 1 cycle.
- Minimum total cycles with out_ready tied high and pipe_idle tied high: LOG_N*(N/4 + 1) + 1 from start to done.
- Reset mid-transform aborts immediately. No done is issued; the next start begins from stage 0.

## Test plan
- Forward, N=8, out_ready=1, pipe_idle=1:
  - stage 0: (0,4,1,5 tf 1,1), (2,6,3,7 tf 1,1)
  - stage 1: (0,2,1,3 tf 2,2), (4,6,5,7 tf 3,3)
  - stage 2: (0,1,2,3 tf 4,5), (4,5,6,7 tf 6,7)
  - done pulses at cycle 10 after start.
- Inverse, N=8:
  - stage 0: (0,1,2,3 tf 7,6), (4,5,6,7 tf 5,4)
  - stage 1: (0,2,1,3 tf 3,3), (4,6,5,7 tf 2,2)
  - stage 2: (0,4,1,5 tf 1,1), (2,6,3,7 tf 1,1)
  - out_is_intt=1 throughout.
- Backpressure: drop out_ready for 3 cycles mid-stage -> payload frozen, no descriptor duplicated or skipped, total transfers = 6.
- Stage barrier: hold pipe_idle=0 for 5 cycles after each out_last -> out_valid stays 0 for those cycles and resumes with the correct stage+1 indices.
- Ignored start: pulse start with is_intt toggled while busy -> sequence and mode unchanged, single done pulse.
- Reset mid-operation: assert reset_n=0 during stage 1 -> all outputs 0 immediately. A new start produces stage-0 descriptors, with no stale done.
